clk_div_sched: RTL and testbench

- Run-time controller for the two-channel toggle clock divider datapath.
- Sequences start/stop of divided clocks clkA/clkB and accepts half-period reconfiguration through a valid/ready handshake.
- New divisors apply only at a channel's toggle boundary, so no output ever shows a runt phase.
- Sits between the system clock domain and downstream logic that consumes slow clocks or one-cycle tick strobes.

---
 rtl/clk_div_sched.sv | 170 +++++++++++++++++
 tb/tb_clk_div_sched.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/clk_div_sched.sv
// Run-time controller for the two-channel toggle clock divider.
// Starts and stops the divided clocks clkA/clkB. It also accepts new
// half-periods through a valid/ready handshake. While a channel is running,
// a new half-period waits in a single pending slot. It takes effect only on
// that channel's toggle, so no output phase is ever cut short.
module clk_div_sched #(
    parameter int CNT_W      = 16,
    parameter int DEF_HALF_A = 4,
    parameter int DEF_HALF_B = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_sel,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             running,
    output logic             clkA,
    output logic             clkB,
    output logic             tickA,
    output logic             tickB
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } stateT;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    stateT            state;
    stateT            nextState;

    logic [CNT_W-1:0] cntA;
    logic [CNT_W-1:0] cntB;
    logic [CNT_W-1:0] halfA;
    logic [CNT_W-1:0] halfB;

    logic             pendValid;
    logic             pendSel;
    logic [CNT_W-1:0] pendHalf;

    logic             activeA;
    logic             activeB;
    logic             toggleA;
    logic             toggleB;
    logic             drainDone;
    logic             cfgFire;
    logic [CNT_W-1:0] cfgHalfEff;
    logic             applyPendA;
    logic             applyPendB;

    assign cfg_ready = ~pendValid;
    assign running   = (state != IDLE);

    // State register for the start/run/drain sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state, per-channel toggle decisions and config routing.
    // During drain, a channel only advances while its clock is high. Once it
    // has fallen, it stays frozen until both channels are low.
    always_comb begin
        nextState  = state;
        activeA    = 1'b0;
        activeB    = 1'b0;
        drainDone  = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                activeA = 1'b1;
                activeB = 1'b1;
                if (stop) begin
                    nextState = DRAIN;
                end
            end
            DRAIN: begin
                activeA   = clkA;
                activeB   = clkB;
                drainDone = !clkA && !clkB;
                if (drainDone) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        toggleA    = activeA && (cntA == halfA);
        toggleB    = activeB && (cntB == halfB);
        cfgFire    = cfg_valid && cfg_ready;
        cfgHalfEff = (cfg_half == '0) ? ONE : cfg_half;
        applyPendA = pendValid && !pendSel && (toggleA || drainDone);
        applyPendB = pendValid &&  pendSel && (toggleB || drainDone);
    end

    // Divider datapath: counters, divided clocks, ticks, half-periods and the pending slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            cntA      <= ONE;
            cntB      <= ONE;
            halfA     <= CNT_W'(DEF_HALF_A);
            halfB     <= CNT_W'(DEF_HALF_B);
            clkA      <= 1'b0;
            clkB      <= 1'b0;
            tickA     <= 1'b0;
            tickB     <= 1'b0;
            pendValid <= 1'b0;
            pendSel   <= 1'b0;
            pendHalf  <= '0;
        end else begin
            tickA <= toggleA;
            tickB <= toggleB;

            if (toggleA) begin
                clkA <= ~clkA;
            end
            if (toggleB) begin
                clkB <= ~clkB;
            end

            if (state == IDLE || drainDone || toggleA) begin
                cntA <= ONE;
            end else if (activeA) begin
                cntA <= cntA + ONE;
            end

            if (state == IDLE || drainDone || toggleB) begin
                cntB <= ONE;
            end else if (activeB) begin
                cntB <= cntB + ONE;
            end

            if (cfgFire && state == IDLE && !cfg_sel) begin
                halfA <= cfgHalfEff;
            end else if (applyPendA) begin
                halfA <= pendHalf;
            end

            if (cfgFire && state == IDLE && cfg_sel) begin
                halfB <= cfgHalfEff;
            end else if (applyPendB) begin
                halfB <= pendHalf;
            end

            if (cfgFire && state != IDLE) begin
                pendValid <= 1'b1;
                pendSel   <= cfg_sel;
                pendHalf  <= cfgHalfEff;
            end else if (applyPendA || applyPendB) begin
                pendValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed testbench for clk_div_sched.
// Inputs change 1 time unit after each rising edge, and outputs are checked at that same point.
module tb_clk_div_sched;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic             cfg_sel = 1'b0;
    logic [CNT_W-1:0] cfg_half = '0;
    logic             running;
    logic             clkA;
    logic             clkB;
    logic             tickA;
    logic             tickB;

    int checks = 0;
    int errors = 0;

    clk_div_sched #(
        .CNT_W      (CNT_W),
        .DEF_HALF_A (4),
        .DEF_HALF_B (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_sel   (cfg_sel),
        .cfg_half  (cfg_half),
        .running   (running),
        .clkA      (clkA),
        .clkB      (clkB),
        .tickA     (tickA),
        .tickB     (tickB)
    );

    always #5 clk = ~clk;

    // Drive one set of inputs and advance past the next rising edge.
    task automatic applyStimulus(input logic r, input logic s, input logic p,
                                 input logic v, input logic sel,
                                 input logic [CNT_W-1:0] h);
        reset     = r;
        start     = s;
        stop      = p;
        cfg_valid = v;
        cfg_sel   = sel;
        cfg_half  = h;
        @(posedge clk);
        #1;
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic eClkA, input logic eClkB,
                               input logic eTickA, input logic eTickB,
                               input logic eRun, input logic eRdy);
        checkBit({tag, ".clkA"},    clkA,      eClkA);
        checkBit({tag, ".clkB"},    clkB,      eClkB);
        checkBit({tag, ".tickA"},   tickA,     eTickA);
        checkBit({tag, ".tickB"},   tickB,     eTickB);
        checkBit({tag, ".running"}, running,   eRun);
        checkBit({tag, ".ready"},   cfg_ready, eRdy);
    endtask

    // With halves hA/hB, a channel toggles every h cycles after RUN is entered.
    task automatic runChecked(input string tag, input int n, input int hA, input int hB);
        for (int k = 1; k <= n; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
            checkOutput($sformatf("%s.k%0d", tag, k),
                        1'(((k / hA) % 2) == 1), 1'(((k / hB) % 2) == 1),
                        1'((k % hA) == 0), 1'((k % hB) == 0), 1'b1, 1'b1);
        end
    endtask

    initial begin
        $display("[TB] start");

        // Reset values
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("reset", 0, 0, 0, 0, 0, 1);

        // Default halves 4/2
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("def.k0", 0, 0, 0, 0, 1, 1);
        runChecked("def", 12, 4, 2);

        // Stop while clkA high and clkB low: B freezes, A finishes its high phase
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("drain13", 1, 0, 0, 0, 1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("drain14", 1, 0, 0, 0, 1, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("drain15", 1, 0, 0, 0, 1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("drain16", 0, 0, 1, 0, 1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("drain17", 0, 0, 0, 0, 0, 1);

        // Config in IDLE applies directly: halfA = 3
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3);
        checkOutput("idleCfg", 0, 0, 0, 0, 0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("run3.k0", 0, 0, 0, 0, 1, 1);
        runChecked("run3", 10, 3, 2);

        // Mid-phase config of B=5, then a second request (A, half 0 -> 1) while pending
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd5);
        checkOutput("pend.j11", 1, 1, 0, 0, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        checkOutput("pend.j12", 0, 0, 1, 1, 1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        checkOutput("pend.j13", 0, 0, 0, 0, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("pend.j14", 0, 0, 0, 0, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("pend.j15", 1, 0, 1, 0, 1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("pend.j16", 0, 0, 1, 0, 1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("pend.j17", 1, 1, 1, 1, 1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("pend.j18", 0, 1, 1, 0, 1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("pend.j19", 1, 1, 1, 0, 1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("pend.j20", 0, 1, 1, 0, 1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("pend.j21", 1, 1, 1, 0, 1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("pend.j22", 0, 0, 1, 1, 1, 1);

        // Pending config, then reset mid-run
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd7);
        checkOutput("pend.j23", 1, 0, 1, 0, 1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("midReset", 0, 0, 0, 0, 0, 1);

        // start and stop together: stays IDLE
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("startStop", 0, 0, 0, 0, 0, 1);

        // Halves back at defaults after reset
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("post.k0", 0, 0, 0, 0, 1, 1);
        runChecked("post", 8, 4, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
